weight_loader: RTL and testbench

- Writer side of the layer weight memory: accepts a stream of 16-bit weight words over a valid/ready handshake and writes them, in order, into the weight RAM write port (address, data, write-enable).
- The neuron layer reads the same memory by address.
- Sits between the host/data source and the weight RAM; asserts done once the full weight set is loaded, so the layer's run can be gated on it.

---
 rtl/weight_loader.sv | 140 ++++++++++++++
 tb/tb_weight_loader.sv | 274 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/weight_loader.sv
// weight_loader: writer side of the layer weight memory.
// Takes a valid/ready stream of weight words and writes them in order to the
// weight RAM write port, one word per cycle. Raises done once DEPTH words have
// been written and keeps a running modulo-2^DATA_W checksum of the load.
//
//   state  | meaning
//   -------+---------------------------------------------------------------
//   IDLE   | after reset; waits for start, in_ready low
//   LOAD   | accepting words; in_ready high; one RAM write per accepted word
//   DONE   | full set written; done high, checksum held; start reloads
module weight_loader #(
    parameter int DATA_W = 16,
    parameter int DEPTH  = 16,
    parameter int ADDR_W = 4
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data,
    output logic              mem_wren,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] checksum
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_LOAD = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(DEPTH - 1);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] count_q, count_d;
    logic [ADDR_W-1:0] mem_address_q, mem_address_d;
    logic [DATA_W-1:0] mem_data_q, mem_data_d;
    logic              mem_wren_q, mem_wren_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [DATA_W-1:0] checksum_q, checksum_d;
    logic              accept;
    logic              last_word;

    // State register and all datapath flops; reset wins over everything,
    // which also drops a write pending from a handshake on the reset edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= S_IDLE;
            count_q       <= '0;
            mem_address_q <= '0;
            mem_data_q    <= '0;
            mem_wren_q    <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
            checksum_q    <= '0;
        end else begin
            state_q       <= state_d;
            count_q       <= count_d;
            mem_address_q <= mem_address_d;
            mem_data_q    <= mem_data_d;
            mem_wren_q    <= mem_wren_d;
            busy_q        <= busy_d;
            done_q        <= done_d;
            checksum_q    <= checksum_d;
        end
    end

    // Next-state logic; start is only honoured outside LOAD.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (start) state_d = S_LOAD;
            S_LOAD:  if (accept && last_word) state_d = S_DONE;
            S_DONE:  if (start) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // FSM outputs; in_ready decodes the state register only, never in_valid.
    always_comb begin
        in_ready  = (state_q == S_LOAD);
        accept    = in_ready && in_valid;
        last_word = (count_q == LAST_IDX);
    end

    // Datapath: register the write one cycle after the handshake, advance the
    // count and accumulate the checksum (carry out discarded).
    always_comb begin
        count_d       = count_q;
        mem_address_d = mem_address_q;
        mem_data_d    = mem_data_q;
        mem_wren_d    = 1'b0;
        busy_d        = busy_q;
        done_d        = done_q;
        checksum_d    = checksum_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    count_d    = '0;
                    checksum_d = '0;
                    busy_d     = 1'b1;
                    done_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    mem_address_d = count_q;
                    mem_data_d    = in_data;
                    mem_wren_d    = 1'b1;
                    count_d       = count_q + 1'b1;
                    checksum_d    = checksum_q + in_data;
                    if (last_word) begin
                        busy_d = 1'b0;
                        done_d = 1'b1;
                    end
                end
            end
            default: begin
                busy_d = 1'b0;
                done_d = 1'b0;
            end
        endcase
    end

    // Registered outputs straight off the flops.
    always_comb begin
        mem_address = mem_address_q;
        mem_data    = mem_data_q;
        mem_wren    = mem_wren_q;
        busy        = busy_q;
        done        = done_q;
        checksum    = checksum_q;
    end

endmodule

// File: tb/tb_weight_loader.sv
// Directed bench for weight_loader: hand-computed expectations, writes
// captured on the falling edge and compared against expected sequences.
module tb_weight_loader;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic [3:0]  mem_address;
    logic [15:0] mem_data;
    logic        mem_wren;
    logic        busy;
    logic        done;
    logic [15:0] checksum;

    int n_chk = 0;
    int n_bad = 0;

    logic [3:0]  wr_addr [0:31];
    logic [15:0] wr_data [0:31];
    int n_wr   = 0;
    int run    = 0;
    int maxrun = 0;

    weight_loader #(.DATA_W(16), .DEPTH(16), .ADDR_W(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_data     (in_data),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .mem_address (mem_address),
        .mem_data    (mem_data),
        .mem_wren    (mem_wren),
        .busy        (busy),
        .done        (done),
        .checksum    (checksum)
    );

    always #5 clk = ~clk;

    // Capture every write strobe and track the longest back-to-back run.
    always @(negedge clk) begin
        if (mem_wren) begin
            if (n_wr < 32) begin
                wr_addr[n_wr] = mem_address;
                wr_data[n_wr] = mem_data;
            end
            n_wr = n_wr + 1;
            run  = run + 1;
            if (run > maxrun) maxrun = run;
        end else begin
            run = 0;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h want 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_log();
        n_wr   = 0;
        run    = 0;
        maxrun = 0;
    endtask

    // Expected write i: address i, data d0 + i*inc.
    task automatic verify_writes(input string tag, input logic [15:0] d0, input logic [15:0] inc);
        logic [15:0] e;
        chk({tag, "_nwr"}, 32'(n_wr), 32'd16);
        for (int i = 0; i < 16; i++) begin
            e = d0 + 16'(i) * inc;
            chk({tag, "_addr"}, 32'(wr_addr[i]), 32'(i));
            chk({tag, "_data"}, 32'(wr_data[i]), 32'(e));
        end
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_rdy"},  32'(in_ready),    32'd0);
        chk({tag, "_wren"}, 32'(mem_wren),    32'd0);
        chk({tag, "_addr"}, 32'(mem_address), 32'd0);
        chk({tag, "_data"}, 32'(mem_data),    32'd0);
        chk({tag, "_busy"}, 32'(busy),        32'd0);
        chk({tag, "_done"}, 32'(done),        32'd0);
        chk({tag, "_csum"}, 32'(checksum),    32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    initial begin
        reset    = 1'b1;
        start    = 1'b0;
        in_data  = '0;
        in_valid = 1'b0;
        tick();
        tick();
        check_reset_vals("rst");
        reset = 1'b0;
        tick();

        // 1: sixteen back-to-back words 1..16
        clear_log();
        pulse_start();
        chk("t1_busy", 32'(busy), 32'd1);
        chk("t1_rdy",  32'(in_ready), 32'd1);
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("t1_done_last", 32'(done), 32'd1);
        chk("t1_wren_last", 32'(mem_wren), 32'd1);
        chk("t1_rdy_done",  32'(in_ready), 32'd0);
        chk("t1_busy_done", 32'(busy), 32'd0);
        tick();
        tick();
        verify_writes("t1", 16'h0001, 16'h0001);
        chk("t1_run",  32'(maxrun), 32'd16);
        chk("t1_csum", 32'(checksum), 32'h0088);

        // 2: same stream with a 3-cycle valid gap after word 5
        clear_log();
        pulse_start();
        chk("t2_done_clr", 32'(done), 32'd0);
        chk("t2_csum_clr", 32'(checksum), 32'd0);
        for (int i = 0; i < 16; i++) begin
            if (i == 5) begin
                in_valid = 1'b0;
                for (int g = 0; g < 3; g++) begin
                    tick();
                    chk("t2_gap_wren", 32'(mem_wren), 32'd0);
                end
            end
            in_valid = 1'b1;
            in_data  = 16'(i + 1);
            tick();
        end
        in_valid = 1'b0;
        chk("t2_done", 32'(done), 32'd1);
        tick();
        tick();
        verify_writes("t2", 16'h0001, 16'h0001);
        chk("t2_run",  32'(maxrun), 32'd11);
        chk("t2_csum", 32'(checksum), 32'h0088);

        // 3: all-ones words wrap the checksum; valid held after the last word
        clear_log();
        pulse_start();
        in_valid = 1'b1;
        in_data  = 16'hFFFF;
        for (int i = 0; i < 16; i++) tick();
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3_rdy_held", 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        tick();
        verify_writes("t3", 16'hFFFF, 16'h0000);
        chk("t3_done", 32'(done), 32'd1);
        chk("t3_csum", 32'(checksum), 32'hFFF0);

        // 4: start during LOAD is ignored; restart after done clears state
        clear_log();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'(i + 1);
            start    = (i == 8);
            tick();
        end
        start    = 1'b0;
        in_valid = 1'b0;
        tick();
        tick();
        verify_writes("t4", 16'h0001, 16'h0001);
        chk("t4_done", 32'(done), 32'd1);
        chk("t4_csum", 32'(checksum), 32'h0088);
        pulse_start();
        chk("t4_re_done", 32'(done), 32'd0);
        chk("t4_re_csum", 32'(checksum), 32'd0);
        chk("t4_re_busy", 32'(busy), 32'd1);
        in_valid = 1'b1;
        in_data  = 16'h1234;
        tick();
        in_valid = 1'b0;
        chk("t4_re_wren", 32'(mem_wren), 32'd1);
        chk("t4_re_addr", 32'(mem_address), 32'd0);
        chk("t4_re_data", 32'(mem_data), 32'h1234);
        chk("t4_re_csum2", 32'(checksum), 32'h1234);

        // 5: reset after 7 words, then a full reload
        reset = 1'b1;
        tick();
        reset = 1'b0;
        tick();
        clear_log();
        pulse_start();
        for (int i = 0; i < 7; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0050 + 16'(i);
            tick();
        end
        reset    = 1'b1;
        in_data  = 16'h0057;
        tick();
        check_reset_vals("t5_rst");
        reset    = 1'b0;
        tick();
        tick();
        chk("t5_rdy_idle", 32'(in_ready), 32'd0);
        in_valid = 1'b0;
        tick();
        chk("t5_nwr7", 32'(n_wr), 32'd7);
        clear_log();
        pulse_start();
        for (int i = 0; i < 16; i++) begin
            in_valid = 1'b1;
            in_data  = 16'h0100 + 16'(i);
            tick();
        end
        in_valid = 1'b0;
        tick();
        tick();
        verify_writes("t5", 16'h0100, 16'h0001);
        chk("t5_csum", 32'(checksum), 32'h1078);

        // 6: valid held in IDLE, first write lands two cycles after start
        reset = 1'b1;
        tick();
        reset = 1'b0;
        clear_log();
        in_valid = 1'b1;
        in_data  = 16'hAAAA;
        for (int i = 0; i < 3; i++) tick();
        chk("t6_idle_nwr", 32'(n_wr), 32'd0);
        chk("t6_idle_rdy", 32'(in_ready), 32'd0);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("t6_e0_wren", 32'(mem_wren), 32'd0);
        tick();
        chk("t6_e1_wren", 32'(mem_wren), 32'd1);
        chk("t6_e1_addr", 32'(mem_address), 32'd0);
        chk("t6_e1_data", 32'(mem_data), 32'hAAAA);
        in_valid = 1'b0;
        tick();

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout: got running want finished");
        $fatal(1, "timeout");
    end

endmodule
